// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared widths and arbiter state type for the UART transmit path
package uart_tx_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } ARB_STATE;

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin picker; scans upward from the slot after last_grant
module rr_select #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_req
);

    always_comb begin
        logic [IDW-1:0] cand;
        logic           found;
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        // Offset NREQ wraps back to last_grant itself, so it is considered last.
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_grant) + k) % NREQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin owner of the word-to-byte transmit serializer
// Optional watchdog built when TXARB_WATCHDOG_EN is defined.
module tx_arbiter
    import uart_tx_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         reqValid,
    input  logic [NREQ*WORD_W-1:0]  reqData,
    output logic [NREQ-1:0]         reqAck,
    output logic                    txValid,
    output logic [WORD_W-1:0]       txData,
    input  logic                    txReady,
    output logic [$clog2(NREQ)-1:0] grantId,
    output logic                    busy,
    output logic                    timeoutErr
);

    localparam int IDW = $clog2(NREQ);

    ARB_STATE        state;
    logic [IDW-1:0]  last_grant;
    logic [NREQ-1:0] pick;
    logic [IDW-1:0]  pick_idx;
    logic            any_req;
    logic            wd_fire;

    rr_select #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_select (
        .req        (reqValid),
        .last_grant (last_grant),
        .grant      (pick),
        .grant_idx  (pick_idx),
        .any_req    (any_req)
    );

`ifdef TXARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt;

    // Fires on the TIMEOUT-th cycle spent outside IDLE since the grant.
    assign wd_fire = (state != IDLE) && (wd_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt     <= '0;
            timeoutErr <= 1'b0;
        end else begin
            if (state == IDLE) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_fire) begin
                timeoutErr <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign wd_fire        = 1'b0;
    assign timeoutErr     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            txValid    <= 1'b0;
            txData     <= '0;
            reqAck     <= '0;
            grantId    <= '0;
            busy       <= 1'b0;
            last_grant <= IDW'(NREQ - 1);
        end else begin
            reqAck <= '0;
            case (state)
                IDLE: begin
                    if (txReady && any_req) begin
                        txData     <= reqData[WORD_W*pick_idx +: WORD_W];
                        grantId    <= pick_idx;
                        reqAck     <= pick;
                        last_grant <= pick_idx;
                        txValid    <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // txReady dropping means the serializer took the word.
                    if (!txReady) begin
                        txValid <= 1'b0;
                        state   <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (txReady) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    txValid <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
            if (wd_fire) begin
                txValid <= 1'b0;
                busy    <= 1'b0;
                state   <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb/tb_tx_arbiter.sv - self-checking bench for tx_arbiter with a serializer model and reference model
module tb_tx_arbiter;

    localparam int NREQ = 3;
    localparam int IDW  = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      reqValid;
    logic [NREQ*32-1:0]   reqData;
    logic [NREQ-1:0]      reqAck;
    logic                 txValid;
    logic [31:0]          txData;
    logic                 txReady;
    logic [IDW-1:0]       grantId;
    logic                 busy;
    logic                 timeoutErr;

    int tests = 0;
    int fails = 0;

    // Reference model: phase 0 free, 1 word offered, 2 serializer draining
    int              m_phase;
    int              m_last;
    logic [NREQ-1:0] e_ack;
    logic            e_valid;
    logic            e_busy;
    logic [31:0]     e_data;
    logic [IDW-1:0]  e_gid;

    int              ser_cnt;
    logic            force_low;
    logic            rand_on;
    logic [NREQ-1:0] hold_mask;
    logic [31:0]     words_q[$];
    logic [7:0]      fifo[$];
    int              dut_grants[$];

    always #5 clk = ~clk;

    tx_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .reqValid   (reqValid),
        .reqData    (reqData),
        .reqAck     (reqAck),
        .txValid    (txValid),
        .txData     (txData),
        .txReady    (txReady),
        .grantId    (grantId),
        .busy       (busy),
        .timeoutErr (timeoutErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [NREQ-1:0]    p_rv;
        logic [NREQ*32-1:0] p_rd;
        logic               p_tr;
        logic               p_rst;
        logic               p_tv;
        logic [31:0]        p_td;
        logic [31:0]        exp_w;
        p_rv  = reqValid;
        p_rd  = reqData;
        p_tr  = txReady;
        p_rst = rst;
        p_tv  = txValid;
        p_td  = txData;
        @(posedge clk);
        #1;
        e_ack = '0;
        if (p_rst) begin
            m_phase = 0;
            m_last  = NREQ - 1;
            e_valid = 1'b0;
            e_busy  = 1'b0;
            e_data  = '0;
            e_gid   = '0;
            words_q.delete();
        end else if (m_phase == 0) begin
            if (p_tr && p_rv != '0) begin
                int w;
                w = -1;
                for (int k = 1; k <= NREQ; k++)
                    if (w < 0 && p_rv[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
                e_ack[w] = 1'b1;
                e_data   = p_rd[32*w +: 32];
                e_gid    = w[IDW-1:0];
                e_valid  = 1'b1;
                e_busy   = 1'b1;
                m_last   = w;
                m_phase  = 1;
                words_q.push_back(e_data);
            end
        end else if (m_phase == 1) begin
            if (!p_tr) begin
                e_valid = 1'b0;
                m_phase = 2;
            end
        end else if (p_tr) begin
            e_busy  = 1'b0;
            m_phase = 0;
        end
        chk("reqAck", reqAck, e_ack);
        chk("ack_onehot0", $onehot0(reqAck), 1'b1);
        chk("txValid", txValid, e_valid);
        chk("txData", txData, e_data);
        chk("grantId", grantId, e_gid);
        chk("busy", busy, e_busy);
        chk("timeoutErr", timeoutErr, 1'b0);
        if (reqAck != '0) dut_grants.push_back(int'(grantId));
        // Serializer: takes a word on valid&ready, then stays busy while pushing bytes
        if (p_rst) begin
            ser_cnt = 0;
            fifo.delete();
        end else if (p_tr && p_tv) begin
            if (words_q.size() > 0) exp_w = words_q.pop_front();
            else exp_w = ~p_td;
            chk("accepted_word", p_td, exp_w);
            for (int b = 0; b < 4; b++) fifo.push_back(p_td[8*b +: 8]);
            ser_cnt = 4 + $urandom_range(0, 3);
        end else if (ser_cnt > 0) begin
            ser_cnt--;
        end
        if (rand_on && m_phase == 0 && ser_cnt == 0 && $urandom_range(0, 7) == 0)
            ser_cnt = $urandom_range(1, 3);
        txReady  = (ser_cnt == 0) && !force_low;
        reqValid = (reqValid & ~reqAck) | hold_mask;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(m_phase == 0 && ser_cnt == 0) && n < 50) begin
            step();
            n++;
        end
        chk("idle_reached", (m_phase == 0 && ser_cnt == 0), 1'b1);
    endtask

    initial begin
        logic [7:0] exp_b[4];
        int         exp_g[4];
        int         n;
        rst       = 1'b1;
        reqValid  = '0;
        reqData   = '0;
        txReady   = 1'b1;
        force_low = 1'b0;
        rand_on   = 1'b0;
        hold_mask = '0;
        ser_cnt   = 0;
        m_phase   = 0;
        m_last    = NREQ - 1;
        e_valid   = 1'b0;
        e_busy    = 1'b0;
        e_data    = '0;
        e_gid     = '0;
        step();
        rst = 1'b0;
        chk("reset_busy", busy, 1'b0);
        chk("reset_txValid", txValid, 1'b0);

`ifdef TXARB_WATCHDOG_EN
        // Serializer stuck with txReady high: word never taken
        reqData[31:0] = 32'h0BAD0BAD;
        reqValid      = 3'b001;
        @(posedge clk);
        #1;
        reqValid = '0;
        repeat (15) @(posedge clk);
        #1;
        chk("wd_not_yet", timeoutErr, 1'b0);
        chk("wd_valid_held", txValid, 1'b1);
        @(posedge clk);
        #1;
        chk("wd_fired", timeoutErr, 1'b1);
        chk("wd_txValid", txValid, 1'b0);
        chk("wd_busy", busy, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("wd_sticky", timeoutErr, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
`endif

        // Single request
        fifo.delete();
        reqData[31:0] = 32'hA1B2C3D4;
        reqValid      = 3'b001;
        step();
        chk("single_ack", reqAck, 3'b001);
        chk("single_data", txData, 32'hA1B2C3D4);
        chk("single_gid", grantId, 0);
        n = 0;
        while (fifo.size() < 4 && n < 20) begin
            step();
            n++;
        end
        chk("single_bytes_count", fifo.size(), 4);
        exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        for (int i = 0; i < 4 && i < fifo.size(); i++) chk("single_byte", fifo[i], exp_b[i]);
        wait_idle();

        // Contention: 0 was granted last, so 1 goes first
        reqData[31:0]  = 32'h11111111;
        reqData[63:32] = 32'h22222222;
        hold_mask      = 3'b011;
        reqValid       = 3'b011;
        dut_grants.delete();
        n = 0;
        while (dut_grants.size() < 4 && n < 100) begin
            step();
            n++;
        end
        hold_mask = '0;
        reqValid  = '0;
        chk("contention_count", dut_grants.size(), 4);
        exp_g = '{1, 0, 1, 0};
        for (int i = 0; i < 4 && i < dut_grants.size(); i++)
            chk("contention_order", dut_grants[i], exp_g[i]);
        wait_idle();

        // Serializer busy from a foreign source
        force_low      = 1'b1;
        txReady        = 1'b0;
        reqData[63:32] = 32'h0F0F0F0F;
        reqValid       = 3'b010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("held_no_ack", reqAck, 3'b000);
            chk("held_no_valid", txValid, 1'b0);
        end
        force_low = 1'b0;
        txReady   = 1'b1;
        step();
        chk("release_ack", reqAck, 3'b010);
        chk("release_gid", grantId, 1);
        wait_idle();

        // Withdrawal before grant, then late data change after grant
        force_low     = 1'b1;
        txReady       = 1'b0;
        reqData[31:0] = 32'hCAFEF00D;
        reqValid      = 3'b001;
        step();
        reqValid  = '0;
        force_low = 1'b0;
        txReady   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("withdraw_no_ack", reqAck, 3'b000);
        end
        reqData[63:32] = 32'h12345678;
        reqValid       = 3'b010;
        step();
        chk("late_ack", reqAck, 3'b010);
        reqData[63:32] = 32'hDEADBEEF;
        step();
        step();
        chk("late_change", txData, 32'h12345678);
        wait_idle();

        // Reset while the serializer drains a word
        reqData[95:64] = 32'h55AA55AA;
        reqValid       = 3'b100;
        n = 0;
        while (m_phase != 2 && n < 20) begin
            step();
            n++;
        end
        chk("reached_wait_done", m_phase, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_reset_busy", busy, 1'b0);
        chk("mid_reset_txValid", txValid, 1'b0);
        chk("mid_reset_txData", txData, 32'h0);
        chk("mid_reset_gid", grantId, 0);
        chk("mid_reset_ack", reqAck, 3'b000);
        reqData  = {32'h33333333, 32'h22222222, 32'h11111111};
        reqValid = 3'b111;
        step();
        chk("post_reset_ack", reqAck, 3'b001);
        chk("post_reset_gid", grantId, 0);

        // Randomized traffic with withdrawals and foreign serializer holds
        rand_on = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!reqValid[i]) begin
                    reqData[32*i +: 32] = $urandom();
                    if ($urandom_range(0, 3) == 0) reqValid[i] = 1'b1;
                end else if ($urandom_range(0, 15) == 0) begin
                    reqValid[i] = 1'b0;
                end
            end
            step();
        end
        rand_on  = 1'b0;
        reqValid = '0;
        wait_idle();
        chk("no_words_lost", words_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
